// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: read-mode constants,
// a constant-foldable clog2 and the parameter legality check.
package fifo_pkg;

   localparam int unsigned FIFO_MODE_STD  = 0;
   localparam int unsigned FIFO_MODE_FWFT = 1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (value > (32'd1 << i)) result = i + 1;
      end
      return result;
   endfunction

   function automatic bit is_pow2(input int unsigned value);
      return (value != 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit params_legal(input int unsigned data_w,
                                       input int unsigned depth,
                                       input int unsigned fwft,
                                       input int unsigned af_thresh,
                                       input int unsigned ae_thresh);
      return (data_w >= 1) && (depth >= 2) && is_pow2(depth) &&
             (fwft <= FIFO_MODE_FWFT) &&
             (af_thresh >= 1) && (af_thresh <= depth) &&
             (ae_thresh <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DATA_W x DEPTH register array, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]         rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy count,
// programmable almost-full/almost-empty and sticky overflow/underflow flags.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned FWFT      = FIFO_MODE_STD,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       fifo_in,
   input  logic                    fifo_wreq,
   input  logic                    fifo_rdeq,
   input  logic                    err_clr,
   output logic [DATA_W-1:0]       fifo_out,
   output logic                    fifo_wrfull,
   output logic                    fifo_rdempty,
   output logic                    fifo_almost_full,
   output logic                    fifo_almost_empty,
   output logic [clog2(DEPTH):0]   fifo_count,
   output logic                    fifo_overflow,
   output logic                    fifo_underflow
);

   localparam int unsigned AW       = clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0] AF_CNT   = (AW + 1)'(AF_THRESH);
   localparam logic [AW:0] AE_CNT   = (AW + 1)'(AE_THRESH);
   localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

   if (!params_legal(DATA_W, DEPTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("sync_fifo_param: illegal parameter combination");
   end

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_ok, rd_ok;
   logic [DATA_W-1:0] mem_rdata;

   // Status comes only from registered state, so full/empty gate the access even
   // when the opposite port is accepted in the same cycle.
   assign fifo_wrfull       = (count_q == FULL_CNT);
   assign fifo_rdempty      = (count_q == '0);
   assign fifo_almost_full  = (count_q >= AF_CNT);
   assign fifo_almost_empty = (count_q <= AE_CNT);
   assign fifo_count        = count_q;
   assign fifo_overflow     = ovf_q;
   assign fifo_underflow    = unf_q;

   assign wr_ok = fifo_wreq & ~fifo_wrfull;
   assign rd_ok = fifo_rdeq & ~fifo_rdempty;

   always_comb begin
      wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = wr_ptr_d - rd_ptr_d;
      // A new error in the same cycle as err_clr must not be lost.
      ovf_d    = (fifo_wreq & fifo_wrfull) | (ovf_q & ~err_clr);
      unf_d    = (fifo_rdeq & fifo_rdempty) | (unf_q & ~err_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (fifo_in),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (mem_rdata)
   );

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign fifo_out = fifo_rdempty ? '0 : mem_rdata;
   end else begin : g_std
      logic [DATA_W-1:0] dout_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q <= '0;
         end else if (rd_ok) begin
            dout_q <= mem_rdata;
         end
      end

      assign fifo_out = dout_q;
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench: one standard-mode and one FWFT instance, 16 x 32 each.
module tb_sync_fifo_param;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] s_in, s_out;
   logic        s_wreq, s_rdeq, s_clr;
   logic        s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic [4:0]  s_cnt;

   logic [31:0] f_in, f_out;
   logic        f_wreq, f_rdeq, f_clr;
   logic        f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [4:0]  f_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(
      .DATA_W (32),
      .DEPTH  (16),
      .FWFT   (0)
   ) u_std (
      .clk               (clk),
      .rst               (rst),
      .fifo_in           (s_in),
      .fifo_wreq         (s_wreq),
      .fifo_rdeq         (s_rdeq),
      .err_clr           (s_clr),
      .fifo_out          (s_out),
      .fifo_wrfull       (s_full),
      .fifo_rdempty      (s_empty),
      .fifo_almost_full  (s_af),
      .fifo_almost_empty (s_ae),
      .fifo_count        (s_cnt),
      .fifo_overflow     (s_ovf),
      .fifo_underflow    (s_unf)
   );

   sync_fifo_param #(
      .DATA_W (32),
      .DEPTH  (16),
      .FWFT   (1)
   ) u_fwft (
      .clk               (clk),
      .rst               (rst),
      .fifo_in           (f_in),
      .fifo_wreq         (f_wreq),
      .fifo_rdeq         (f_rdeq),
      .err_clr           (f_clr),
      .fifo_out          (f_out),
      .fifo_wrfull       (f_full),
      .fifo_rdempty      (f_empty),
      .fifo_almost_full  (f_af),
      .fifo_almost_empty (f_ae),
      .fifo_count        (f_cnt),
      .fifo_overflow     (f_ovf),
      .fifo_underflow    (f_unf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      s_in   = '0; s_wreq = 1'b0; s_rdeq = 1'b0; s_clr = 1'b0;
      f_in   = '0; f_wreq = 1'b0; f_rdeq = 1'b0; f_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values
      check("rst_count", 32'(s_cnt), 0);
      check("rst_empty", 32'(s_empty), 1);
      check("rst_full", 32'(s_full), 0);
      check("rst_ae", 32'(s_ae), 1);
      check("rst_af", 32'(s_af), 0);
      check("rst_out", s_out, 0);
      check("rst_ovf", 32'(s_ovf), 0);
      check("rst_unf", 32'(s_unf), 0);
      check("rst_fwft_out", f_out, 0);
      rst = 1'b0;

      // Fill with 0..15; almost-full from 14, almost-empty up to 2
      for (int i = 0; i < 16; i++) begin
         s_wreq = 1'b1;
         s_in   = 32'(i);
         tick();
         check("fill_count", 32'(s_cnt), 32'(i + 1));
         check("fill_af", 32'(s_af), (i + 1 >= 14) ? 1 : 0);
         check("fill_ae", 32'(s_ae), (i + 1 <= 2) ? 1 : 0);
      end
      check("fill_full", 32'(s_full), 1);
      check("fill_no_ovf", 32'(s_ovf), 0);
      s_in = 32'h99;
      tick();
      s_wreq = 1'b0;
      check("ovf_set", 32'(s_ovf), 1);
      check("ovf_count", 32'(s_cnt), 16);

      // Drain in order, then one extra read
      for (int i = 0; i < 16; i++) begin
         s_rdeq = 1'b1;
         tick();
         check("drain_data", s_out, 32'(i));
      end
      check("drain_empty", 32'(s_empty), 1);
      check("drain_count", 32'(s_cnt), 0);
      tick();
      s_rdeq = 1'b0;
      check("unf_set", 32'(s_unf), 1);
      check("unf_out_hold", s_out, 32'hF);
      check("unf_count", 32'(s_cnt), 0);

      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      check("clr_ovf", 32'(s_ovf), 0);
      check("clr_unf", 32'(s_unf), 0);

      // Steady state at count 5 across pointer wrap
      for (int i = 0; i < 5; i++) begin
         s_wreq = 1'b1;
         s_in   = 32'(100 + i);
         tick();
      end
      check("steady_pre_count", 32'(s_cnt), 5);
      s_rdeq = 1'b1;
      for (int i = 0; i < 40; i++) begin
         s_in = 32'(105 + i);
         tick();
         check("steady_data", s_out, 32'(100 + i));
         check("steady_count", 32'(s_cnt), 5);
      end
      s_wreq = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("steady_tail", s_out, 32'(140 + i));
      end
      s_rdeq = 1'b0;
      check("steady_empty", 32'(s_empty), 1);

      // Write + read while empty: write wins, read is an underflow
      s_wreq = 1'b1; s_rdeq = 1'b1; s_in = 32'h77;
      tick();
      s_wreq = 1'b0; s_rdeq = 1'b0;
      check("empty_rw_count", 32'(s_cnt), 1);
      check("empty_rw_unf", 32'(s_unf), 1);
      check("empty_rw_out", s_out, 32'd144);
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      for (int i = 0; i < 15; i++) begin
         s_wreq = 1'b1;
         s_in   = 32'h200 + 32'(i);
         tick();
      end
      check("refill_full", 32'(s_full), 1);

      // Write + read while full: read wins, write is an overflow
      s_wreq = 1'b1; s_rdeq = 1'b1; s_in = 32'h55;
      tick();
      s_wreq = 1'b0;
      check("full_rw_count", 32'(s_cnt), 15);
      check("full_rw_ovf", 32'(s_ovf), 1);
      check("full_rw_out", s_out, 32'h77);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("pre_rst_data", s_out, 32'h200 + 32'(i));
      end
      s_rdeq = 1'b0;
      check("pre_rst_count", 32'(s_cnt), 9);

      // Asynchronous reset mid-cycle
      #3;
      rst = 1'b1;
      #1;
      check("arst_count", 32'(s_cnt), 0);
      check("arst_empty", 32'(s_empty), 1);
      check("arst_full", 32'(s_full), 0);
      check("arst_ae", 32'(s_ae), 1);
      check("arst_ovf", 32'(s_ovf), 0);
      check("arst_out", s_out, 0);
      #2;
      rst = 1'b0;
      s_wreq = 1'b1; s_in = 32'h42;
      tick();
      s_wreq = 1'b0;
      check("post_rst_count", 32'(s_cnt), 1);
      s_rdeq = 1'b1;
      tick();
      check("post_rst_data", s_out, 32'h42);

      // Underflow coinciding with err_clr: the set wins
      s_clr = 1'b1;
      tick();
      check("set_wins_unf", 32'(s_unf), 1);
      s_rdeq = 1'b0;
      tick();
      s_clr = 1'b0;
      check("clr_after_set", 32'(s_unf), 0);

      // FWFT instance
      check("fwft_idle_out", f_out, 0);
      f_wreq = 1'b1; f_in = 32'hA5A5A5A5;
      tick();
      f_wreq = 1'b0;
      check("fwft_show", f_out, 32'hA5A5A5A5);
      check("fwft_count", 32'(f_cnt), 1);
      f_rdeq = 1'b1;
      tick();
      f_rdeq = 1'b0;
      check("fwft_pop_out", f_out, 0);
      check("fwft_pop_empty", 32'(f_empty), 1);
      f_wreq = 1'b1; f_in = 32'h11111111;
      tick();
      f_in = 32'h22222222;
      tick();
      f_wreq = 1'b0;
      check("fwft_head", f_out, 32'h11111111);
      f_rdeq = 1'b1;
      tick();
      check("fwft_next", f_out, 32'h22222222);
      tick();
      check("fwft_drained", f_out, 0);
      tick();
      f_rdeq = 1'b0;
      check("fwft_unf", 32'(f_unf), 1);
      check("fwft_unf_out", f_out, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the 16x32 ROM-to-RAM staging buffer. Configurable width, power-of-two depth and read mode (standard or first-word-fall-through), with occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Sits between a producer (ROM reader) and a consumer (RAM writer) sharing one clock domain.

## Interface
Parameters:
- DATA_W, 32, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- FWFT, 0, 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
- AF_THRESH, DEPTH-2, fifo_almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, fifo_almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports (AW = clog2(DEPTH)):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_in  in  DATA_W  write data
- fifo_wreq  in  1  write request
- fifo_rdeq  in  1  read request
- err_clr  in  1  synchronous clear of the sticky error flags
- fifo_out  out  DATA_W  read data
- fifo_wrfull  out  1  count == DEPTH
- fifo_rdempty  out  1  count == 0
- fifo_almost_full  out  1  count ≥ AF_THRESH
- fifo_almost_empty  out  1  count ≤ AE_THRESH
- fifo_count  out  AW+1  current occupancy, 0..DEPTH
- fifo_overflow  out  1  sticky: write attempted while full
- fifo_underflow  out  1  sticky: read attempted while empty

## Operation
- Write accepted (wr_ok) = fifo_wreq & !fifo_wrfull; stores fifo_in at wr_ptr, wr_ptr++.
- Read accepted (rd_ok) = fifo_rdeq & !fifo_rdempty; rd_ptr++.
- Full gates writes even when a read is accepted in the same cycle; empty gates reads even when a write is accepted in the same cycle.
- Pointers are AW+1 bits; the low AW bits index storage; wrap from DEPTH-1 to 0 is natural binary rollover. fifo_count = wr_ptr - rd_ptr (mod 2^(AW+1)), held in a register.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Standard mode: on rd_ok, fifo_out <= mem[rd_ptr] at that edge; otherwise fifo_out holds its value.
- FWFT mode: fifo_out = mem[rd_ptr] whenever !fifo_rdempty, otherwise 0; rd_ok pops the displayed word.
- Rejected write sets fifo_overflow; rejected read sets fifo_underflow. Both flags hold until err_clr or rst. When a set event and err_clr coincide, set wins.
- Rejected accesses leave pointers, count, storage and fifo_out unchanged.

## Timing
- Reset values: pointers 0, fifo_count 0, fifo_rdempty 1, fifo_wrfull 0, fifo_almost_empty 1, fifo_almost_full 0, fifo_out 0, both error flags 0. Storage contents are not reset.
- Reset mid-operation discards all contents immediately (asynchronous). First access is accepted on the first rising edge after rst deasserts.
- All status flags are decoded from registered count and pointers. They reflect an access on the edge it is accepted, i.e. they are valid one cycle after the request cycle.
- Write-to-read latency: a word written at edge N is readable at edge N+1. Standard mode: fifo_out shows the word after edge N+1 if rdeq is high. FWFT mode: fifo_out shows the word immediately after edge N when the FIFO was empty.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Shared package fifo_pkg: clog2 function, FIFO_MODE_STD/FIFO_MODE_FWFT constants, parameter legality checks (DEPTH power of two, threshold ranges).
- One sub-module, fifo_mem: DATA_W x DEPTH register array with a synchronous write port and an asynchronous read port. The top level holds pointers, count, flags and the output register.

## Test plan
- Reset, then write 16 words 0x0..0xF (DEPTH=16, std mode) -> fifo_count=16, fifo_wrfull=1, fifo_almost_full from count 14; a 17th write sets fifo_overflow and leaves count=16.
- Read 16 words from full -> fifo_out sequence 0x0..0xF, each one cycle after its rdeq; fifo_rdempty=1 after the last; an extra read sets fifo_underflow and fifo_out holds 0xF.
- Simultaneous wreq+rdeq at count 5 for 40 cycles -> count stays 5; data stays in order across pointer wrap.
- Simultaneous wreq+rdeq when empty -> write accepted, read rejected, underflow=1, count=1. The same case when full -> read accepted, write rejected, overflow=1, count=15.
- FWFT=1: write 0xA5A5A5A5 into an empty FIFO -> fifo_out=0xA5A5A5A5 the cycle after the write with no rdeq; rdeq pops it and fifo_out returns to 0.
- Assert rst mid-stream at count 9 -> all outputs take their reset values without waiting for a clock edge; err_clr clears sticky flags after injected errors.
